// File: rtl/mem_data_arbiter_pkg.sv
// Shared types and constants for the two-port data-RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_BYTES_DEF = 80;
  localparam int unsigned RO_BYTES_DEF  = 4;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RDONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/mem_data_arbiter_if.sv
// Requester ports, RAM bus and FSM debug view of the data-RAM arbiter.
// Handshake: req rises with we/addr/wdata stable and stays high until the
// one-cycle gnt; done (with rsp_err/rsp_rdata) follows later as a one-cycle pulse.
interface mem_data_arbiter_if;
  import mem_arb_pkg::*;

  logic        p0_req,   p1_req;
  logic        p0_we,    p1_we;
  logic [31:0] p0_addr,  p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt,   p1_gnt;
  logic        p0_done,  p1_done;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;
  state_t      dbg_state;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
           p0_wdata, p1_wdata, mem_rdata,
    output p0_gnt, p1_gnt, p0_done, p1_done, rsp_err, rsp_rdata,
           mem_addr, mem_wdata, mem_write, dbg_state
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
           p0_wdata, p1_wdata, mem_rdata,
    input  p0_gnt, p1_gnt, p0_done, p1_done, rsp_err, rsp_rdata,
           mem_addr, mem_wdata, mem_write, dbg_state
  );

endinterface

// File: rtl/mem_data_arbiter_rr_arbiter2.sv
// Two-request round-robin pick; `last` moves to the winner only when the
// grant is actually taken.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       pick
);

  logic last;

  always_comb begin
    pick = PORT_CORE;
    case (req)
      2'b01:   pick = PORT_CORE;
      2'b10:   pick = PORT_DBG;
      2'b11:   pick = ~last;
      default: pick = PORT_CORE;
    endcase
  end

  // Reset to the debug port so the core wins the very first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= PORT_DBG;
    else if (update) last <= pick;
  end

endmodule

// File: rtl/mem_data_arbiter.sv
// Serializes core/debug accesses to the data RAM and sequences writes as
// setup / one-cycle strobe / hold so address and data bracket the strobe.
module mem_data_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned RO_BYTES  = RO_BYTES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_data_arbiter_if.slave  bus
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);
  localparam logic [31:0] RO_LIMIT  = 32'(RO_BYTES);

  state_t      state, state_next;
  logic        owner, cap_we;
  logic        take, pick, legal, resp;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        write_q;

  // Gate with rst_n so no grant leaks out while reset is held.
  assign take = (state == ST_IDLE) && (bus.p0_req || bus.p1_req) && rst_n;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({bus.p1_req, bus.p0_req}),
    .update (take),
    .pick   (pick)
  );

  assign sel_we    = pick ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = pick ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = pick ? bus.p1_wdata : bus.p0_wdata;
  assign legal     = (sel_addr <= LAST_ADDR) && !(sel_we && (sel_addr < RO_LIMIT));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (take) state_next = legal ? ST_SETUP : ST_ERR;
      ST_SETUP:  state_next = cap_we ? ST_STROBE : ST_RDONE;
      ST_STROBE: state_next = ST_HOLD;
      ST_HOLD,
      ST_RDONE,
      ST_ERR:    state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // The RAM bus only loads on legal grants so rejected accesses never move it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner   <= PORT_CORE;
      cap_we  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state   <= state_next;
      write_q <= (state_next == ST_STROBE);
      if (take) begin
        owner   <= pick;
        cap_we  <= sel_we;
        rdata_q <= '0;
        if (legal) begin
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
        end
      end
      if (state == ST_SETUP && !cap_we) rdata_q <= bus.mem_rdata;
    end
  end

  assign resp          = (state == ST_HOLD) || (state == ST_RDONE) || (state == ST_ERR);
  assign bus.p0_gnt    = take && (pick == PORT_CORE);
  assign bus.p1_gnt    = take && (pick == PORT_DBG);
  assign bus.p0_done   = resp && (owner == PORT_CORE);
  assign bus.p1_done   = resp && (owner == PORT_DBG);
  assign bus.rsp_err   = (state == ST_ERR);
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_write = write_q;
  assign bus.dbg_state = state;

endmodule
